// File: rtl/lenet_layer_sequencer_if.sv
// Request/control bundle between the host front end and the LeNet layer sequencer.
interface lenet_layer_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_index;
  logic        abort;
  logic        l1_last;
  logic        layer_done;
  logic [2:0]  layer;
  logic [15:0] index;
  logic        state_changed;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] images_done;

  modport master (
    output req_valid, req_index, abort, l1_last, layer_done,
    input  req_ready, layer, index, state_changed, busy, done, err, err_code, images_done
  );

  modport slave (
    input  req_valid, req_index, abort, l1_last, layer_done,
    output req_ready, layer, index, state_changed, busy, done, err, err_code, images_done
  );
endinterface

// File: rtl/lenet_layer_sequencer.sv
// Per-image LeNet layer scheduler: steps layers 1->2->3 with inter-layer gaps and a per-layer watchdog.
//   state | meaning
//   IDLE  | waiting for an image request (req_ready high)
//   RUN   | layer cur active, waiting for its completion, watchdog counting
//   GAP   | idle gap between layers, layer output 000
//   DONE  | one-cycle completion pulse after layer 3
module lenet_layer_sequencer #(
  parameter int TOTAL_IMAGE_NUM = 1000,
  parameter int GAP_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  lenet_layer_sequencer_if.slave    sif
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [31:0]      IDX_LIM  = 32'(TOTAL_IMAGE_NUM);
  localparam bit               WD_EN    = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cur_q, cur_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [2:0]       layer_q, layer_d;
  logic [15:0]      index_q, index_d;
  logic             sc_q, sc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [15:0]      images_done_q, images_done_d;

  logic accept, idx_bad, comp, wd_hit;

  // abort blocks a coincident request even though req_ready is high
  assign accept  = (state_q == S_IDLE) && sif.req_valid && !sif.abort;
  assign idx_bad = {16'h0000, sif.req_index} >= IDX_LIM;
  assign comp    = (cur_q == 2'd1) ? sif.l1_last : sif.layer_done;
  assign wd_hit  = WD_EN && (wd_cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_q         <= 2'd1;
      gap_cnt_q     <= '0;
      wd_cnt_q      <= '0;
      layer_q       <= 3'b000;
      index_q       <= 16'h0000;
      sc_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
      images_done_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      gap_cnt_q     <= gap_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      layer_q       <= layer_d;
      index_q       <= index_d;
      sc_q          <= sc_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      images_done_q <= images_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    gap_cnt_d = gap_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    if (sif.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && !idx_bad) begin
            state_d  = S_RUN;
            cur_d    = 2'd1;
            wd_cnt_d = '0;
          end
        end
        S_RUN: begin
          // completion on the watchdog's last cycle still counts as completion
          if (comp) begin
            wd_cnt_d = '0;
            if (cur_q == 2'd3) begin
              state_d = S_DONE;
            end else if (GAP_CYCLES > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end else begin
              cur_d = cur_q + 2'd1;
            end
          end else if (wd_hit) begin
            state_d = S_IDLE;
          end else if (WD_EN) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = S_RUN;
            cur_d   = cur_q + 2'd1;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    layer_d       = (state_d == S_RUN) ? 3'(3'b001 << (cur_d - 2'd1)) : 3'b000;
    sc_d          = (state_d == S_RUN) && ((state_q != S_RUN) || (cur_d != cur_q));
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    index_d       = index_q;
    images_done_d = images_done_q;
    if (accept) begin
      if (idx_bad) begin
        err_d      = 1'b1;
        err_code_d = 2'b01;
      end else begin
        index_d    = sif.req_index;
        err_code_d = 2'b00;
      end
    end
    if (!sif.abort && (state_q == S_RUN) && !comp && wd_hit) begin
      err_d      = 1'b1;
      err_code_d = 2'b10;
    end
    if (done_d) images_done_d = images_done_q + 16'd1;
  end

  assign sif.req_ready     = (state_q == S_IDLE);
  assign sif.layer         = layer_q;
  assign sif.index         = index_q;
  assign sif.state_changed = sc_q;
  assign sif.busy          = busy_q;
  assign sif.done          = done_q;
  assign sif.err           = err_q;
  assign sif.err_code      = err_code_q;
  assign sif.images_done   = images_done_q;
endmodule
